// File: rtl/rl_ram_pkg.sv
// Shared constants and helpers for the one-write / N-read RAM.
package rl_ram_pkg;

  localparam string RL_BYPASS    = "BYPASS";
  localparam string RL_DONT_CARE = "DONT_CARE";

  localparam int RL_MAX_DBITS = 256;
  localparam int RL_MAX_BBITS = RL_MAX_DBITS / 8;

  function automatic int rl_bbits(input int dbits);
    return (dbits + 7) / 8;
  endfunction

  // Bits at or above dbits stay clear, so a partial top lane only covers its real bits.
  function automatic logic [RL_MAX_DBITS-1:0] rl_be_mask(input logic [RL_MAX_BBITS-1:0] be,
                                                         input int dbits);
    logic [RL_MAX_DBITS-1:0] m;
    m = '0;
    for (int i = 0; i < RL_MAX_DBITS; i++)
      m[i] = (i < dbits) && be[i/8];
    return m;
  endfunction

endpackage

// File: rtl/rl_ram_rdport.sv
// One read port: contention detect, per-byte write-first merge, valid tracking.
// RL_RAM_OUTREG_EN adds a second output register stage (latency 2).
module rl_ram_rdport
  import rl_ram_pkg::*;
#(
  parameter int    ABITS         = 10,
  parameter int    DBITS         = 32,
  parameter string RW_CONTENTION = "BYPASS"
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             re_i,
  input  logic [ABITS-1:0] raddr_i,
  input  logic [DBITS-1:0] rword_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [DBITS-1:0] din_i,
  input  logic [DBITS-1:0] wmask_i,
  output logic [DBITS-1:0] dout_o,
  output logic             dvalid_o
);

`ifdef RL_RAM_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [STAGES:0]  vld_pipe;
  logic [STAGES:1]  vld_q;
  logic [DBITS-1:0] rword_q;
  logic [DBITS-1:0] merged;

  assign vld_pipe = {vld_q, re_i & ~rst_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      rword_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (re_i) rword_q <= rword_i;
    end
  end

  if (RW_CONTENTION == RL_BYPASS) begin : g_bypass
    logic             hit;
    logic [DBITS-1:0] din_q;
    logic [DBITS-1:0] mask_q;

    assign hit = we_i && (raddr_i == waddr_i);

    // Mask is registered already qualified by hit, so a miss merges nothing.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        din_q  <= '0;
        mask_q <= '0;
      end else if (re_i) begin
        din_q  <= din_i;
        mask_q <= hit ? wmask_i : '0;
      end
    end

    assign merged = (rword_q & ~mask_q) | (din_q & mask_q);
  end else begin : g_raw
    assign merged = rword_q;
  end

`ifdef RL_RAM_OUTREG_EN
  logic [DBITS-1:0] dout_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)            dout_q <= '0;
    else if (vld_pipe[1]) dout_q <= merged;
  end
  assign dout_o = dout_q;
`else
  assign dout_o = merged;
`endif

  assign dvalid_o = vld_pipe[STAGES];

endmodule

// File: rtl/rl_ram_1wnr.sv
// One-write, NR-read RAM with byte enables and per-port contention merge.
// Define RL_RAM_OUTREG_EN for a registered output (read latency 2).
module rl_ram_1wnr
  import rl_ram_pkg::*;
#(
  parameter int    ABITS         = 10,
  parameter int    DBITS         = 32,
  parameter int    NR            = 2,
  parameter string INIT_FILE     = "",
  parameter string RW_CONTENTION = "BYPASS"
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ABITS-1:0]          waddr_i,
  input  logic [DBITS-1:0]          din_i,
  input  logic                      we_i,
  input  logic [rl_bbits(DBITS)-1:0] be_i,
  input  logic [NR*ABITS-1:0]       raddr_i,
  input  logic [NR-1:0]             re_i,
  output logic [NR*DBITS-1:0]       dout_o,
  output logic [NR-1:0]             dvalid_o
);

  localparam int DEPTH = 2 ** ABITS;

  logic [DBITS-1:0] mem [DEPTH];
  logic [DBITS-1:0] wmask;

  assign wmask = DBITS'(rl_be_mask(RL_MAX_BBITS'(be_i), DBITS));

  always_ff @(posedge clk_i) begin
    if (!rst_i && we_i)
      mem[waddr_i] <= (mem[waddr_i] & ~wmask) | (din_i & wmask);
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    rl_ram_rdport #(
      .ABITS        (ABITS),
      .DBITS        (DBITS),
      .RW_CONTENTION(RW_CONTENTION)
    ) u_rdport (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .re_i    (re_i[p]),
      .raddr_i (raddr_i[p*ABITS +: ABITS]),
      .rword_i (mem[raddr_i[p*ABITS +: ABITS]]),
      .we_i    (we_i),
      .waddr_i (waddr_i),
      .din_i   (din_i),
      .wmask_i (wmask),
      .dout_o  (dout_o[p*DBITS +: DBITS]),
      .dvalid_o(dvalid_o[p])
    );
  end

endmodule

// File: tb/tb_rl_ram_1wnr.sv
// Bench for rl_ram_1wnr: byte-level memory model plus directed literal checks.
module tb_rl_ram_1wnr;
  localparam int ABITS = 4;
  localparam int DBITS = 32;
  localparam int NR    = 2;
`ifdef RL_RAM_OUTREG_EN
  localparam int    L    = 2;
  localparam string MODE = "DONT_CARE";
  localparam bit    DCM  = 1'b1;
`else
  localparam int    L    = 1;
  localparam string MODE = "BYPASS";
  localparam bit    DCM  = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ABITS-1:0]  waddr;
  logic [DBITS-1:0]  din;
  logic              we;
  logic [3:0]        be;
  logic [NR*ABITS-1:0] raddr;
  logic [NR-1:0]     re;
  wire  [NR*DBITS-1:0] dout;
  wire  [NR-1:0]     dvalid;

  always #5 clk = ~clk;

  rl_ram_1wnr #(
    .ABITS(ABITS), .DBITS(DBITS), .NR(NR), .INIT_FILE(""), .RW_CONTENTION(MODE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
    .raddr_i(raddr), .re_i(re), .dout_o(dout), .dvalid_o(dvalid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  // Model: memory image and, per port, what should appear after 1 and 2 edges.
  logic [31:0] mm  [16];
  logic [31:0] sd  [NR][2];
  logic        sv  [NR][2];
  logic        sdc [NR][2];

  always @(posedge clk) begin : model
    logic [3:0] a;
    for (int p = 0; p < NR; p++) begin
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          sd[p][k] = '0; sv[p][k] = 1'b0; sdc[p][k] = 1'b0;
        end
      end else begin
        sv[p][1] = sv[p][0];
        if (sv[p][0]) begin
          sd[p][1]  = sd[p][0];
          sdc[p][1] = sdc[p][0];
        end
        sv[p][0] = re[p];
        if (re[p]) begin
          a         = raddr[p*ABITS +: ABITS];
          sd[p][0]  = mm[a];
          sdc[p][0] = 1'b0;
          if (we && a == waddr) begin
            sdc[p][0] = DCM;
            for (int b = 0; b < 4; b++)
              if (be[b]) sd[p][0][b*8 +: 8] = din[b*8 +: 8];
          end
        end
      end
    end
    if (!rst && we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mm[waddr][b*8 +: 8] = din[b*8 +: 8];
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int p = 0; p < NR; p++) begin
        n_tests++;
        if (dvalid[p] !== sv[p][L-1] ||
            (!sdc[p][L-1] && dout[p*DBITS +: DBITS] !== sd[p][L-1])) begin
          n_fail++;
          $display("FAIL model_p%0d t=%0t: dout=%h dvalid=%b, expected dout=%h dvalid=%b",
                   p, $time, dout[p*DBITS +: DBITS], dvalid[p], sd[p][L-1], sv[p][L-1]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; be = 4'h0; re = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; waddr = a; din = d; be = b;
  endtask

  task automatic rd(input int p, input logic [3:0] a);
    re[p] = 1'b1;
    raddr[p*ABITS +: ABITS] = a;
  endtask

  task automatic settle();
    idle();
    repeat (L-1) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle(); waddr = '0; din = '0; raddr = '0;
    tick(); tick();
    chk("rst_dout0", dout[31:0], 32'h0);
    chk("rst_dout1", dout[63:32], 32'h0);
    chk("rst_dvalid", {30'd0, dvalid}, 32'h0);
    rst = 1'b0;
    armed = 1'b1;

    for (int i = 0; i < 16; i++) begin
      idle();
      wr(4'(i), (i == 5) ? 32'h11223344 : (i == 6) ? 32'h66666666 : 32'h01010101 * i, 4'hF);
      tick();
    end

    // Basic write then read
    idle(); wr(4'd3, 32'hDEADBEEF, 4'hF); tick();
    idle(); rd(0, 4'd3); tick(); settle();
    chk("basic_dout0", dout[31:0], 32'hDEADBEEF);
    chk("basic_dvalid0", {31'd0, dvalid[0]}, 32'h1);
    tick();
    chk("basic_pulse_end", {31'd0, dvalid[0]}, 32'h0);

    // Partial collision on port 1
    idle(); wr(4'd5, 32'hAABBCCDD, 4'h5); rd(1, 4'd5); tick(); settle();
`ifndef RL_RAM_OUTREG_EN
    chk("coll_dout1", dout[63:32], 32'h11BB33DD);
`endif
    chk("coll_dvalid1", {31'd0, dvalid[1]}, 32'h1);
    idle(); rd(1, 4'd5); tick(); settle();
    chk("coll_array", dout[63:32], 32'h11BB33DD);

    // Both ports hit the write address
    idle(); wr(4'd5, 32'h11223344, 4'hF); tick();
    idle(); wr(4'd5, 32'hAABBCCDD, 4'h5); rd(0, 4'd5); rd(1, 4'd5); tick(); settle();
`ifndef RL_RAM_OUTREG_EN
    chk("dual_p0", dout[31:0], 32'h11BB33DD);
    chk("dual_p1", dout[63:32], 32'h11BB33DD);
`endif
    idle(); wr(4'd5, 32'hAABBCCDD, 4'h5); rd(0, 4'd6); rd(1, 4'd5); tick(); settle();
    chk("dual_addr6", dout[31:0], 32'h66666666);
`ifndef RL_RAM_OUTREG_EN
    chk("dual_addr5", dout[63:32], 32'h11BB33DD);
`endif

    // Hold while the address is rewritten
    idle(); rd(0, 4'd3); tick(); settle();
    for (int k = 0; k < 4; k++) begin
      idle(); wr(4'd3, 32'h12345678, 4'hF); tick();
      chk("hold_dout0", dout[31:0], 32'hDEADBEEF);
      chk("hold_dvalid0", {31'd0, dvalid[0]}, 32'h0);
    end
    idle(); wr(4'd3, 32'hDEADBEEF, 4'hF); tick();

    // Reset in the cycle after a read, with a write to address 3
    idle(); rd(0, 4'd3); tick();
    rst = 1'b1; idle(); wr(4'd3, 32'h0, 4'hF); rd(0, 4'd3); tick();
    chk("rst_mid_dout0", dout[31:0], 32'h0);
    chk("rst_mid_dout1", dout[63:32], 32'h0);
    chk("rst_mid_dvalid", {30'd0, dvalid}, 32'h0);
    idle(); tick();
    chk("rst_no_pulse", {30'd0, dvalid}, 32'h0);
    rst = 1'b0;
    idle(); rd(0, 4'd3); tick(); settle();
    chk("post_rst_dout0", dout[31:0], 32'hDEADBEEF);
    chk("post_rst_dvalid0", {31'd0, dvalid[0]}, 32'h1);

    // Full throughput: write and both reads every cycle
    for (int i = 0; i < 40; i++) begin
      we    = 1'b1;
      waddr = 4'(i * 7);
      din   = 32'h9E3779B9 * (i + 1);
      be    = 4'(i * 3 + 1);
      re    = 2'b11;
      raddr[3:0] = 4'(i);
      raddr[7:4] = (i % 3 == 0) ? 4'(i * 7) : 4'(i * 11);
      tick();
    end
    idle(); repeat (L + 1) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
